// File: rtl/vec_csr_pkg.sv
// Shared types and constants for the vector CSR unit: vtype layout, decode constants, FSM states.
package vec_csr_pkg;

  localparam int VT_XLEN = 32;

  localparam logic [6:0] OPC_VEC = 7'h57;
  localparam logic [2:0] F3_CFG  = 3'b111;

  typedef struct packed {
    logic               vill;
    logic [VT_XLEN-10:0] reserved;
    logic               vma;
    logic               vta;
    logic [2:0]         vsew;
    logic [2:0]         vlmul;
  } vtype_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } csr_state_e;

endpackage

// File: rtl/vec_vlmax_calc.sv
// Combinational VLMAX and vtype legality check; zero latency, no flow control.
module vec_vlmax_calc
  import vec_csr_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int VLEN = 512,
  parameter int ELEN = 32
) (
  input  logic [XLEN-1:0]        vtype_raw,
  output logic                   vill,
  output logic [$clog2(VLEN):0]  vlmax
);

  localparam int VLW = $clog2(VLEN) + 1;
  localparam logic signed [6:0] VLEN_L2 = 7'($clog2(VLEN));
  localparam logic signed [6:0] ELEN_L2 = 7'($clog2(ELEN));

  vtype_t vt;
  logic signed [6:0] sew_l2;
  logic signed [6:0] lmul_l2;
  logic signed [6:0] vlmax_l2;
  logic              rsvd_nz;
  logic              unused_bits;

  assign vt = vtype_t'(vtype_raw);

  // Everything is done in log2 space: fractional LMUL is a negative exponent.
  assign sew_l2   = {4'b0, vt.vsew} + 7'sd3;
  assign lmul_l2  = {{4{vt.vlmul[2]}}, vt.vlmul};
  assign vlmax_l2 = VLEN_L2 - sew_l2 + lmul_l2;
  assign rsvd_nz  = |vt.reserved;

  assign vill = (vt.vlmul == 3'b100) || (sew_l2 > ELEN_L2) ||
                (vt.vlmul[2] && (sew_l2 > ELEN_L2 + lmul_l2)) || rsvd_nz;

  assign vlmax = vill ? '0 : (VLW'(1) << vlmax_l2[4:0]);

  assign unused_bits = ^{vt.vill, vt.vma, vt.vta, vlmax_l2[6:5]};

endmodule

// File: rtl/vec_csr_unit.sv
// Vector configuration CSR unit (vsetvli/vsetivli/vsetvl); response 2 cycles after accept.
// One instruction in flight; response held stable until resp_ready_i.
module vec_csr_unit
  import vec_csr_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int VLEN = 512,
  parameter int ELEN = 32
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            inst_valid_i,
  output logic            inst_ready_o,
  input  logic [XLEN-1:0] vec_inst_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            is_vec_inst_o,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_wdata_o,
  output logic [XLEN-1:0] vl_o,
  output logic [XLEN-1:0] vtype_o,
  output logic [XLEN-1:0] vstart_o,
  input  logic            vstart_we_i,
  input  logic [XLEN-1:0] vstart_wdata_i
);

  localparam int VLW = $clog2(VLEN) + 1;
  localparam int VSW = $clog2(VLEN);
  localparam logic [XLEN-1:0] VILL_VTYPE = {1'b1, {(XLEN-1){1'b0}}};

  csr_state_e state, state_nxt;

  logic            is_vsetvli, is_vsetivli, is_vsetvl, is_cfg, xfer;
  logic [XLEN-1:0] avl_q, vtype_q;
  logic [4:0]      rd_q;
  logic            rs1_zero_q, ivli_q;
  logic [VLW-1:0]  vl_q, vl_new, vlmax;
  logic            vill;
  logic [VSW-1:0]  vstart_q;
  logic            unused_wdata;

  assign is_vec_inst_o = (vec_inst_i[6:0] == OPC_VEC);
  assign is_vsetvli    = !vec_inst_i[31];
  assign is_vsetivli   = (vec_inst_i[31:30] == 2'b11);
  assign is_vsetvl     = (vec_inst_i[31:25] == 7'b1000000);
  assign is_cfg        = is_vec_inst_o && (vec_inst_i[14:12] == F3_CFG) &&
                         (is_vsetvli || is_vsetivli || is_vsetvl);

  assign inst_ready_o = (state == IDLE);
  assign resp_valid_o = (state == RESP);
  assign xfer         = inst_valid_i && inst_ready_o && is_cfg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (resp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture: normalise the three encodings into (AVL, raw vtype).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      avl_q      <= '0;
      vtype_q    <= '0;
      rd_q       <= '0;
      rs1_zero_q <= 1'b0;
      ivli_q     <= 1'b0;
    end else if (xfer) begin
      ivli_q     <= is_vsetivli;
      rs1_zero_q <= (vec_inst_i[19:15] == 5'd0);
      rd_q       <= vec_inst_i[11:7];
      avl_q      <= is_vsetivli ? XLEN'(vec_inst_i[19:15]) : rs1_i;
      if (is_vsetivli)     vtype_q <= XLEN'(vec_inst_i[29:20]);
      else if (is_vsetvli) vtype_q <= XLEN'(vec_inst_i[30:20]);
      else                 vtype_q <= rs2_i;
    end
  end

  vec_vlmax_calc #(.XLEN(XLEN), .VLEN(VLEN), .ELEN(ELEN)) u_vlmax (
    .vtype_raw (vtype_q),
    .vill      (vill),
    .vlmax     (vlmax)
  );

  always_comb begin
    if (vill)                        vl_new = '0;
    else if (!rs1_zero_q || ivli_q)  vl_new = (avl_q < XLEN'(vlmax)) ? avl_q[VLW-1:0] : vlmax;
    else if (rd_q != 5'd0)           vl_new = vlmax;
    else                             vl_new = (vl_q < vlmax) ? vl_q : vlmax;
  end

  // CSRs commit on the CALC->RESP edge; that commit also wins over a vstart write.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vl_q       <= '0;
      vtype_o    <= VILL_VTYPE;
      vstart_q   <= '0;
      rd_addr_o  <= '0;
      rd_wdata_o <= '0;
    end else if (state == CALC) begin
      vl_q       <= vl_new;
      vtype_o    <= vill ? VILL_VTYPE : {{(XLEN-8){1'b0}}, vtype_q[7:0]};
      vstart_q   <= '0;
      rd_addr_o  <= rd_q;
      rd_wdata_o <= XLEN'(vl_new);
    end else if (vstart_we_i) begin
      vstart_q   <= vstart_wdata_i[VSW-1:0];
    end
  end

  assign vl_o     = XLEN'(vl_q);
  assign vstart_o = XLEN'(vstart_q);

  assign unused_wdata = ^vstart_wdata_i[XLEN-1:VSW];

endmodule

// File: doc/vec_csr_unit.md
VEC_CSR_UNIT -- requirements
Module: vec_csr_unit

Interface
REQ-001 Parameters SHALL be: XLEN 32 (scalar/CSR width); VLEN 512 (vector register bits, power of 2); ELEN 32 (max element bits, 8..64, power of 2).
REQ-002 Port clk, input, 1: single clock; all state on its rising edge.
REQ-003 Port n_rst, input, 1: asynchronous, active-low reset.
REQ-004 Port inst_valid_i, input, 1: vec_inst_i/rs1_i/rs2_i valid.
REQ-005 Port inst_ready_o, output, 1: unit accepts an instruction this cycle.
REQ-006 Port vec_inst_i, input, XLEN: instruction word.
REQ-007 Ports rs1_i and rs2_i, input, XLEN each: scalar operand values.
REQ-008 Port is_vec_inst_o, output, 1: combinational; high when vec_inst_i[6:0]==7'h57.
REQ-009 Ports resp_valid_o (output, 1) and resp_ready_i (input, 1): response handshake.
REQ-010 Ports rd_addr_o (output, 5) and rd_wdata_o (output, XLEN): scalar writeback, valid with resp_valid_o.
REQ-011 Ports vl_o, vtype_o and vstart_o, output, XLEN each: architectural CSRs.
REQ-012 Ports vstart_we_i (input, 1) and vstart_wdata_i (input, XLEN): execution-side vstart write.

Function
REQ-013 A config instruction SHALL be opcode 7'h57 with funct3 3'b111; inst[31]==0 is vsetvli (zimm=inst[30:20], AVL=rs1_i); inst[31:30]==2'b11 is vsetivli (zimm=inst[29:20], AVL=zero-extended inst[19:15]); inst[31:25]==7'b1000000 is vsetvl (vtype=rs2_i, AVL=rs1_i).
REQ-014 inst_ready_o SHALL be high only in state IDLE; a transfer occurs when inst_valid_i && inst_ready_o && the word is a config instruction; non-config words SHALL be ignored and leave the state unchanged.
REQ-015 FSM states SHALL be IDLE -> CALC (unconditional, 1 cycle) -> RESP; RESP -> IDLE on resp_valid_o && resp_ready_i.
REQ-016 Operands SHALL be captured at the transfer edge; CALC SHALL compute VLMAX = (VLEN/SEW)*LMUL, where SEW=8<<vsew and LMUL=2^vlmul for vlmul 0..3 or 1/2^(8-vlmul) for vlmul 5..7.
REQ-017 vtype SHALL be illegal (vill) if vlmul==3'b100, or SEW>ELEN, or fractional LMUL with SEW>ELEN*LMUL, or vtype bits XLEN-2:8 are nonzero.
REQ-018 Legal vl SHALL be: min(AVL, VLMAX) if rs1 field!=0 or vsetivli; VLMAX if rs1==0 and rd!=0; min(current vl, VLMAX) if rs1==0 and rd==0 (non-vsetivli).
REQ-019 Illegal vtype SHALL set vl=0 and vtype_o={1'b1, (XLEN-1){1'b0}}.
REQ-020 vl_o, vtype_o and rd_wdata_o (= new vl) SHALL update on the CALC->RESP edge; rd_addr_o SHALL be inst[11:7]; resp_valid_o SHALL first be high 2 cycles after the transfer.
REQ-021 resp_valid_o, rd_addr_o and rd_wdata_o SHALL hold stable while resp_valid_o && !resp_ready_i.
REQ-022 vstart_o SHALL clear on the CALC->RESP edge; otherwise vstart_we_i loads vstart_wdata_i[$clog2(VLEN)-1:0] zero-extended; a simultaneous config update SHALL take priority.
REQ-023 Internal vl width SHALL be $clog2(VLEN)+1 bits, zero-extended to XLEN; AVL comparison SHALL use the full XLEN value.

Reset
REQ-024 On n_rst low the FSM SHALL return to IDLE immediately, aborting any operation without updating CSRs.
REQ-025 Reset values SHALL be: vl_o=0, vtype_o={1'b1, 0...} (vill), vstart_o=0, resp_valid_o=0, rd_addr_o=0, rd_wdata_o=0.

Structure
REQ-026 Package vec_csr_pkg SHALL hold: vtype_t struct (vill, reserved, vma, vta, vsew, vlmul), opcode/funct3 constants, and the csr_state_e enum.
REQ-027 VLMAX and legality computation SHALL be sub-module vec_vlmax_calc (combinational, parametrised VLEN/ELEN).

Verification (VLEN=512, ELEN=32)
REQ-028 vsetvli 32'h0100F0D7, rs1_i=20 -> resp at transfer+2: rd_addr_o=1, rd_wdata_o=16, vl_o=16, vtype_o=32'h10.
REQ-029 vsetivli 32'hC1087157 -> rd_addr_o=2, vl_o=16, vtype_o=32'h10; then vsetvl 32'h8030F157, rs1_i=15, rs2_i=32'h10 -> vl_o=15.
REQ-030 vsetvl with rs2_i=32'h18 (SEW64>ELEN) -> vl_o=0, vtype_o=32'h8000_0000, rd_wdata_o=0.
REQ-031 Hold resp_ready_i=0 for 3 cycles in RESP -> outputs stable, inst_ready_o=0; new inst_valid_i not accepted until the cycle after the resp handshake.
REQ-032 vstart_we_i with data 5, then a config commit -> vstart_o=5 then 0; assert n_rst in CALC -> IDLE, vl_o=0, vill set.
